// File: rtl/game_round_controller.sv
// Round sequencer for a target/torpedo game: starts a game on a launch press,
// arms and aims the sprites, resolves each shot as a hit or a miss, keeps
// score, lives and level, and hands off to an end-of-game timer.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no game running; results of the last game held
// ARM       | one cycle: load positions and velocities of both sprites
// AIM       | target moving, torpedo steered, waiting for launch
// FLY       | both sprites moving, waiting for collision or an exit
// RESOLVE   | one cycle: apply the hit or miss to score, level and lives
// END_START | one cycle: pulse the end-of-game timer start
// END_WAIT  | wait for the end-of-game timer to finish
module game_round_controller #(
    parameter int LIVES_INIT     = 3,
    parameter int HITS_PER_LEVEL = 4,
    parameter int LEVEL_MAX      = 7,
    parameter int SCORE_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   launch_key,
    input  logic                   collision,
    input  logic                   sprite_target_within_screen,
    input  logic                   sprite_torpedo_within_screen,
    input  logic                   end_of_game_timer_running,
    output logic                   sprite_target_write_xy,
    output logic                   sprite_target_write_dxy,
    output logic                   sprite_torpedo_write_xy,
    output logic                   sprite_torpedo_write_dxy,
    output logic                   sprite_target_enable_update,
    output logic                   sprite_torpedo_enable_update,
    output logic                   end_of_game_timer_start,
    output logic                   game_won,
    output logic                   game_over,
    output logic [SCORE_WIDTH-1:0] score,
    output logic [1:0]             lives,
    output logic [2:0]             level
);

    localparam int HW = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL + 1) : 1;
    // Wide enough to hold score + (level + 1) without wrapping, so the
    // saturation test is a plain compare.
    localparam int AW = ((SCORE_WIDTH > 3) ? SCORE_WIDTH : 3) + 1;
    localparam logic [AW-1:0] SCORE_MAX = AW'({SCORE_WIDTH{1'b1}});

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_AIM, S_FLY, S_RESOLVE, S_END_START, S_END_WAIT
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic                     launch_key_q;
    logic                     launch_ok;
    logic                     running_q;
    logic                     hit_q;
    logic [HW-1:0]            hit_cnt;

    logic                     launch_rise;
    logic                     timer_fall;
    logic [AW-1:0]            score_sum;
    logic [SCORE_WIDTH-1:0]   score_hit;
    logic [HW-1:0]            hit_cnt_inc;
    logic                     level_done;
    logic                     at_last_level;
    logic [1:0]               lives_dec;

    // launch_ok stays low after reset until the key is seen released, so a
    // button held through reset cannot start a game on its own.
    assign launch_rise   = launch_key & ~launch_key_q & launch_ok;
    assign timer_fall    = running_q & ~end_of_game_timer_running;
    assign score_sum     = AW'(score) + AW'(level) + AW'(1);
    assign score_hit     = (score_sum > SCORE_MAX) ? {SCORE_WIDTH{1'b1}}
                                                   : score_sum[SCORE_WIDTH-1:0];
    assign hit_cnt_inc   = hit_cnt + HW'(1);
    assign level_done    = (hit_cnt_inc == HW'(HITS_PER_LEVEL));
    assign at_last_level = (level == 3'(LEVEL_MAX));
    assign lives_dec     = (lives != 2'd0) ? lives - 2'd1 : 2'd0;

    // Input edge detectors for the launch key and the end-of-game timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            launch_key_q <= 1'b0;
            launch_ok    <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            launch_key_q <= launch_key;
            running_q    <= end_of_game_timer_running;
            if (!launch_key) launch_ok <= 1'b1;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (launch_rise) state_nxt = S_ARM;
            S_ARM:       state_nxt = S_AIM;
            S_AIM: begin
                if (launch_rise)                       state_nxt = S_FLY;
                else if (!sprite_target_within_screen) state_nxt = S_ARM;
            end
            S_FLY: begin
                if (collision || !sprite_torpedo_within_screen ||
                    !sprite_target_within_screen)      state_nxt = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (hit_q) state_nxt = (level_done && at_last_level) ? S_END_START : S_ARM;
                else       state_nxt = (lives_dec == 2'd0) ? S_END_START : S_ARM;
            end
            S_END_START: state_nxt = S_END_WAIT;
            S_END_WAIT:  if (timer_fall) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // State register, registered Moore outputs and game bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                        <= S_IDLE;
            sprite_target_write_xy       <= 1'b0;
            sprite_target_write_dxy      <= 1'b0;
            sprite_torpedo_write_xy      <= 1'b0;
            sprite_torpedo_write_dxy     <= 1'b0;
            sprite_target_enable_update  <= 1'b0;
            sprite_torpedo_enable_update <= 1'b0;
            end_of_game_timer_start      <= 1'b0;
            score                        <= '0;
            lives                        <= 2'(LIVES_INIT);
            level                        <= 3'd0;
            hit_cnt                      <= '0;
            hit_q                        <= 1'b0;
            game_won                     <= 1'b0;
            game_over                    <= 1'b0;
        end else begin
            state <= state_nxt;

            sprite_target_write_xy       <= 1'b0;
            sprite_target_write_dxy      <= 1'b0;
            sprite_torpedo_write_xy      <= 1'b0;
            sprite_torpedo_write_dxy     <= 1'b0;
            sprite_target_enable_update  <= 1'b0;
            sprite_torpedo_enable_update <= 1'b0;
            end_of_game_timer_start      <= 1'b0;
            case (state_nxt)
                S_ARM: begin
                    sprite_target_write_xy   <= 1'b1;
                    sprite_target_write_dxy  <= 1'b1;
                    sprite_torpedo_write_xy  <= 1'b1;
                    sprite_torpedo_write_dxy <= 1'b1;
                end
                S_AIM: begin
                    sprite_target_enable_update <= 1'b1;
                    sprite_torpedo_write_dxy    <= 1'b1;
                end
                S_FLY: begin
                    sprite_target_enable_update  <= 1'b1;
                    sprite_torpedo_enable_update <= 1'b1;
                end
                S_END_START: end_of_game_timer_start <= 1'b1;
                default: ;
            endcase

            if (state == S_IDLE && launch_rise) begin
                score     <= '0;
                hit_cnt   <= '0;
                level     <= 3'd0;
                lives     <= 2'(LIVES_INIT);
                game_won  <= 1'b0;
                game_over <= 1'b0;
            end

            // Collision wins over a simultaneous exit.
            if (state == S_FLY) hit_q <= collision;

            if (state == S_RESOLVE) begin
                if (hit_q) begin
                    score <= score_hit;
                    if (level_done) begin
                        hit_cnt <= '0;
                        if (at_last_level) game_won <= 1'b1;
                        else               level    <= level + 3'd1;
                    end else begin
                        hit_cnt <= hit_cnt_inc;
                    end
                end else begin
                    lives <= lives_dec;
                    if (lives_dec == 2'd0) game_won <= 1'b0;
                end
                if (state_nxt == S_END_START) game_over <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_game_round_controller.sv
// Bench for game_round_controller: three parameterisations driven by
// scenario tasks and a random game player, checked against a game-rules model.
module tb_game_round_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic lk[3], col[3], tvis[3], pvis[3], run[3];
    logic wtxy[3], wtdxy[3], wpxy[3], wpdxy[3], ten[3], pen[3], tst[3];
    logic won[3], over[3];
    logic [1:0] lives_a[3];
    logic [2:0] level_a[3];
    logic [7:0] score_a[3];
    logic [7:0] score0, score1;
    logic [2:0] score2;

    assign score_a[0] = score0;
    assign score_a[1] = score1;
    assign score_a[2] = {5'b0, score2};

    game_round_controller #(.LIVES_INIT(3), .HITS_PER_LEVEL(4), .LEVEL_MAX(7), .SCORE_WIDTH(8)) dut0 (
        .clk(clk), .rst(rst), .launch_key(lk[0]), .collision(col[0]),
        .sprite_target_within_screen(tvis[0]), .sprite_torpedo_within_screen(pvis[0]),
        .end_of_game_timer_running(run[0]),
        .sprite_target_write_xy(wtxy[0]), .sprite_target_write_dxy(wtdxy[0]),
        .sprite_torpedo_write_xy(wpxy[0]), .sprite_torpedo_write_dxy(wpdxy[0]),
        .sprite_target_enable_update(ten[0]), .sprite_torpedo_enable_update(pen[0]),
        .end_of_game_timer_start(tst[0]), .game_won(won[0]), .game_over(over[0]),
        .score(score0), .lives(lives_a[0]), .level(level_a[0]));

    game_round_controller #(.LIVES_INIT(3), .HITS_PER_LEVEL(2), .LEVEL_MAX(1), .SCORE_WIDTH(8)) dut1 (
        .clk(clk), .rst(rst), .launch_key(lk[1]), .collision(col[1]),
        .sprite_target_within_screen(tvis[1]), .sprite_torpedo_within_screen(pvis[1]),
        .end_of_game_timer_running(run[1]),
        .sprite_target_write_xy(wtxy[1]), .sprite_target_write_dxy(wtdxy[1]),
        .sprite_torpedo_write_xy(wpxy[1]), .sprite_torpedo_write_dxy(wpdxy[1]),
        .sprite_target_enable_update(ten[1]), .sprite_torpedo_enable_update(pen[1]),
        .end_of_game_timer_start(tst[1]), .game_won(won[1]), .game_over(over[1]),
        .score(score1), .lives(lives_a[1]), .level(level_a[1]));

    game_round_controller #(.LIVES_INIT(3), .HITS_PER_LEVEL(4), .LEVEL_MAX(7), .SCORE_WIDTH(3)) dut2 (
        .clk(clk), .rst(rst), .launch_key(lk[2]), .collision(col[2]),
        .sprite_target_within_screen(tvis[2]), .sprite_torpedo_within_screen(pvis[2]),
        .end_of_game_timer_running(run[2]),
        .sprite_target_write_xy(wtxy[2]), .sprite_target_write_dxy(wtdxy[2]),
        .sprite_torpedo_write_xy(wpxy[2]), .sprite_torpedo_write_dxy(wpdxy[2]),
        .sprite_target_enable_update(ten[2]), .sprite_torpedo_enable_update(pen[2]),
        .end_of_game_timer_start(tst[2]), .game_won(won[2]), .game_over(over[2]),
        .score(score2), .lives(lives_a[2]), .level(level_a[2]));

    // Output signatures: {wtxy, wtdxy, wpxy, wpdxy, ten, pen, tstart}
    localparam logic [6:0] O_QUIET = 7'b0000000;
    localparam logic [6:0] O_ARM   = 7'b1111000;
    localparam logic [6:0] O_AIM   = 7'b0001100;
    localparam logic [6:0] O_FLY   = 7'b0000110;
    localparam logic [6:0] O_ENDST = 7'b0000001;

    int n_cmp = 0;
    int n_bad = 0;

    int P_LIVES[3] = '{3, 3, 3};
    int P_H[3]     = '{4, 2, 4};
    int P_LMAX[3]  = '{7, 1, 7};
    int P_SMAX[3]  = '{255, 255, 7};

    int m_score[3], m_lives[3], m_level[3], m_hits[3];
    bit m_won[3], m_over[3];

    function automatic logic [6:0] outs(int d);
        return {wtxy[d], wtdxy[d], wpxy[d], wpdxy[d], ten[d], pen[d], tst[d]};
    endfunction

    // {score, lives, level, won, over}
    function automatic logic [14:0] obs_stats(int d);
        return {score_a[d], lives_a[d], level_a[d], won[d], over[d]};
    endfunction

    function automatic logic [14:0] exp_stats(int d);
        return {8'(m_score[d]), 2'(m_lives[d]), 3'(m_level[d]), m_won[d], m_over[d]};
    endfunction

    function automatic void model_new_game(int d);
        m_score[d] = 0; m_lives[d] = P_LIVES[d]; m_level[d] = 0;
        m_hits[d] = 0;  m_won[d] = 1'b0;         m_over[d] = 1'b0;
    endfunction

    // Applies one shot to the game rules; returns 1 when the game ends.
    function automatic bit model_shot(int d, bit hit);
        if (hit) begin
            m_score[d] = (m_score[d] + m_level[d] + 1 > P_SMAX[d]) ? P_SMAX[d]
                                                                   : m_score[d] + m_level[d] + 1;
            m_hits[d]++;
            if (m_hits[d] == P_H[d]) begin
                m_hits[d] = 0;
                if (m_level[d] == P_LMAX[d]) begin
                    m_won[d] = 1'b1; m_over[d] = 1'b1;
                    return 1'b1;
                end
                m_level[d]++;
            end
            return 1'b0;
        end
        if (m_lives[d] > 0) m_lives[d]--;
        if (m_lives[d] == 0) begin
            m_won[d] = 1'b0; m_over[d] = 1'b1;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Release then press launch; returns at the sample point after the rise.
    task automatic press_launch(int d);
        lk[d] = 1'b0;
        @(negedge clk);
        lk[d] = 1'b1;
        @(negedge clk);
    endtask

    // From FLY: dwell, then produce outcome kind (0 hit, 1 torpedo exit,
    // 2 target exit, 3 hit with torpedo exit); returns after RESOLVE.
    task automatic resolve_shot(int d, int kind);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        case (kind)
            0: col[d] = 1'b1;
            1: pvis[d] = 1'b0;
            2: tvis[d] = 1'b0;
            default: begin col[d] = 1'b1; pvis[d] = 1'b0; end
        endcase
        @(negedge clk);
        col[d] = 1'b0; pvis[d] = 1'b1; tvis[d] = 1'b1;
        @(negedge clk);
    endtask

    // From END_START: run the timer for a while, then let it fall.
    task automatic end_game(int d, int hold);
        run[d] = 1'b1;
        repeat (hold) @(negedge clk);
        run[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            lk[d] = 1'b0; col[d] = 1'b0; tvis[d] = 1'b1; pvis[d] = 1'b1; run[d] = 1'b0;
            model_new_game(d);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (outs(d) !== O_QUIET) begin
                n_bad++; $display("FAIL reset_outs d%0d: got %b expected %b", d, outs(d), O_QUIET);
            end
            n_cmp++;
            if (obs_stats(d) !== exp_stats(d)) begin
                n_bad++; $display("FAIL reset_stats d%0d: got %h expected %h", d, obs_stats(d), exp_stats(d));
            end
        end
    endtask

    task automatic test_start(int d);
        press_launch(d);
        model_new_game(d);
        n_cmp++;
        if (outs(d) !== O_ARM) begin
            n_bad++; $display("FAIL start_arm d%0d: got %b expected %b", d, outs(d), O_ARM);
        end
        n_cmp++;
        if (obs_stats(d) !== exp_stats(d)) begin
            n_bad++; $display("FAIL start_stats d%0d: got %h expected %h", d, obs_stats(d), exp_stats(d));
        end
        @(negedge clk);
        n_cmp++;
        if (outs(d) !== O_AIM) begin
            n_bad++; $display("FAIL start_aim d%0d: got %b expected %b", d, outs(d), O_AIM);
        end
    endtask

    task automatic test_aim_guards();
        col[0] = 1'b1;
        @(negedge clk);
        col[0] = 1'b0;
        n_cmp++;
        if (outs(0) !== O_AIM) begin
            n_bad++; $display("FAIL aim_collision_ignored: got %b expected %b", outs(0), O_AIM);
        end
        tvis[0] = 1'b0;
        @(negedge clk);
        tvis[0] = 1'b1;
        n_cmp++;
        if (outs(0) !== O_ARM) begin
            n_bad++; $display("FAIL aim_target_exit: got %b expected %b", outs(0), O_ARM);
        end
        n_cmp++;
        if (obs_stats(0) !== exp_stats(0)) begin
            n_bad++; $display("FAIL aim_no_penalty: got %h expected %h", obs_stats(0), exp_stats(0));
        end
    endtask

    task automatic test_hit_level0();
        bit ended;
        press_launch(0);
        n_cmp++;
        if (outs(0) !== O_FLY) begin
            n_bad++; $display("FAIL fly_entry: got %b expected %b", outs(0), O_FLY);
        end
        press_launch(0);
        n_cmp++;
        if (outs(0) !== O_FLY) begin
            n_bad++; $display("FAIL fly_launch_ignored: got %b expected %b", outs(0), O_FLY);
        end
        resolve_shot(0, 0);
        ended = model_shot(0, 1'b1);
        n_cmp++;
        if (outs(0) !== O_ARM || ended) begin
            n_bad++; $display("FAIL hit_rearm: got %b expected %b", outs(0), O_ARM);
        end
        n_cmp++;
        if (score_a[0] !== 8'd1) begin
            n_bad++; $display("FAIL hit_score: got %0d expected 1", score_a[0]);
        end
        press_launch(0);
        resolve_shot(0, 3);
        ended = model_shot(0, 1'b1);
        n_cmp++;
        if (outs(0) !== O_ARM || obs_stats(0) !== exp_stats(0)) begin
            n_bad++; $display("FAIL hit_and_exit: got %b/%h expected %b/%h", outs(0), obs_stats(0), O_ARM, exp_stats(0));
        end
    endtask

    task automatic test_misses();
        bit ended = 1'b0;
        for (int i = 0; i < 3; i++) begin
            press_launch(0);
            resolve_shot(0, (i == 1) ? 2 : 1);
            ended = model_shot(0, 1'b0);
            n_cmp++;
            if (obs_stats(0) !== exp_stats(0)) begin
                n_bad++; $display("FAIL miss_stats_%0d: got %h expected %h", i, obs_stats(0), exp_stats(0));
            end
            n_cmp++;
            if (outs(0) !== (ended ? O_ENDST : O_ARM)) begin
                n_bad++; $display("FAIL miss_next_%0d: got %b expected %b", i, outs(0), ended ? O_ENDST : O_ARM);
            end
        end
        run[0] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (outs(0) !== O_QUIET) begin
            n_bad++; $display("FAIL timer_start_pulse: got %b expected %b", outs(0), O_QUIET);
        end
        press_launch(0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (outs(0) !== O_QUIET) begin
            n_bad++; $display("FAIL end_wait_launch_ignored: got %b expected %b", outs(0), O_QUIET);
        end
        run[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs_stats(0) !== exp_stats(0) || lives_a[0] !== 2'd0 || over[0] !== 1'b1) begin
            n_bad++; $display("FAIL idle_hold: got %h expected %h", obs_stats(0), exp_stats(0));
        end
        test_start(0);
    endtask

    task automatic test_win();
        bit ended = 1'b0;
        test_start(1);
        for (int i = 0; i < 4; i++) begin
            press_launch(1);
            resolve_shot(1, (i == 2) ? 3 : 0);
            ended = model_shot(1, 1'b1);
            n_cmp++;
            if (obs_stats(1) !== exp_stats(1) || outs(1) !== (ended ? O_ENDST : O_ARM)) begin
                n_bad++; $display("FAIL win_hit_%0d: got %h/%b expected %h/%b", i, obs_stats(1), outs(1), exp_stats(1), ended ? O_ENDST : O_ARM);
            end
        end
        n_cmp++;
        if (score_a[1] !== 8'd6 || level_a[1] !== 3'd1 || won[1] !== 1'b1) begin
            n_bad++; $display("FAIL win_final: got score %0d level %0d won %b expected 6 1 1", score_a[1], level_a[1], won[1]);
        end
        end_game(1, 2);
        n_cmp++;
        if (outs(1) !== O_QUIET || obs_stats(1) !== exp_stats(1)) begin
            n_bad++; $display("FAIL win_idle_hold: got %b/%h expected %b/%h", outs(1), obs_stats(1), O_QUIET, exp_stats(1));
        end
    endtask

    task automatic test_saturation();
        bit ended;
        test_start(2);
        for (int i = 0; i < 8; i++) begin
            press_launch(2);
            resolve_shot(2, 0);
            ended = model_shot(2, 1'b1);
            n_cmp++;
            if (obs_stats(2) !== exp_stats(2) || ended) begin
                n_bad++; $display("FAIL sat_hit_%0d: got %h expected %h", i, obs_stats(2), exp_stats(2));
            end
        end
        n_cmp++;
        if (score_a[2] !== 8'd7 || level_a[2] !== 3'd2) begin
            n_bad++; $display("FAIL sat_final: got score %0d level %0d expected 7 2", score_a[2], level_a[2]);
        end
    endtask

    // Plays the current game of instance d to its end with random shots.
    task automatic test_random_game(int d);
        bit ended = 1'b0;
        for (int shot = 0; shot < 80 && !ended; shot++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                tvis[d] = 1'b0;
                @(negedge clk);
                tvis[d] = 1'b1;
                n_cmp++;
                if (outs(d) !== O_ARM) begin
                    n_bad++; $display("FAIL rnd_retreat d%0d: got %b expected %b", d, outs(d), O_ARM);
                end
            end
            press_launch(d);
            n_cmp++;
            if (outs(d) !== O_FLY) begin
                n_bad++; $display("FAIL rnd_fly d%0d: got %b expected %b", d, outs(d), O_FLY);
            end
            if ($urandom_range(0, 9) < 6) begin
                resolve_shot(d, ($urandom_range(0, 1) == 0) ? 0 : 3);
                ended = model_shot(d, 1'b1);
            end else begin
                resolve_shot(d, $urandom_range(1, 2));
                ended = model_shot(d, 1'b0);
            end
            n_cmp++;
            if (obs_stats(d) !== exp_stats(d) || outs(d) !== (ended ? O_ENDST : O_ARM)) begin
                n_bad++; $display("FAIL rnd_shot d%0d: got %h/%b expected %h/%b", d, obs_stats(d), outs(d), exp_stats(d), ended ? O_ENDST : O_ARM);
            end
        end
        if (ended) begin
            end_game(d, $urandom_range(1, 3));
            n_cmp++;
            if (outs(d) !== O_QUIET || obs_stats(d) !== exp_stats(d)) begin
                n_bad++; $display("FAIL rnd_end d%0d: got %b/%h expected %b/%h", d, outs(d), obs_stats(d), O_QUIET, exp_stats(d));
            end
        end
    endtask

    task automatic test_reset_in_flight();
        bit ended;
        test_start(0);
        press_launch(0);
        resolve_shot(0, 0);
        ended = model_shot(0, 1'b1);
        press_launch(0);
        n_cmp++;
        if (outs(0) !== O_FLY || score_a[0] !== 8'd1 || ended) begin
            n_bad++; $display("FAIL rst_setup: got %b score %0d expected %b 1", outs(0), score_a[0], O_FLY);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) model_new_game(d);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (outs(d) !== O_QUIET || obs_stats(d) !== exp_stats(d)) begin
                n_bad++; $display("FAIL rst_flight d%0d: got %b/%h expected %b/%h", d, outs(d), obs_stats(d), O_QUIET, exp_stats(d));
            end
        end
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if (outs(0) !== O_QUIET) begin
                n_bad++; $display("FAIL rst_held_key: got %b expected %b", outs(0), O_QUIET);
            end
        end
        press_launch(0);
        n_cmp++;
        if (outs(0) !== O_ARM) begin
            n_bad++; $display("FAIL rst_repress: got %b expected %b", outs(0), O_ARM);
        end
    endtask

    initial begin
        test_reset();
        test_start(0);
        test_aim_guards();
        test_hit_level0();
        test_misses();
        test_win();
        test_saturation();
        test_random_game(0);
        test_start(1);
        test_random_game(1);
        test_random_game(2);
        test_reset_in_flight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_round_controller.md
GAME_ROUND_CONTROLLER -- requirements
Module: game_round_controller

Interface
REQ-001 Clocking SHALL be one clock `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-002 Parameter LIVES_INIT, default 3: lives loaded at game start, range 1..3.
REQ-003 Parameter HITS_PER_LEVEL, default 4: hits needed to advance one level.
REQ-004 Parameter LEVEL_MAX, default 7: final level; completing it wins the game.
REQ-005 Parameter SCORE_WIDTH, default 8: score counter width.
REQ-006 Ports:
- clk  in  1  system clock
- rst  in  1  sync active-high reset
- launch_key  in  1  raw launch button, level
- collision  in  1  target/torpedo overlap
- sprite_target_within_screen  in  1  target visible
- sprite_torpedo_within_screen  in  1  torpedo visible
- end_of_game_timer_running  in  1  end timer busy
- sprite_target_write_xy  out  1  load target position
- sprite_target_write_dxy  out  1  load target velocity
- sprite_torpedo_write_xy  out  1  load torpedo position
- sprite_torpedo_write_dxy  out  1  load torpedo velocity
- sprite_target_enable_update  out  1  target motion enable
- sprite_torpedo_enable_update  out  1  torpedo motion enable
- end_of_game_timer_start  out  1  one-cycle timer start pulse
- game_won  out  1  last game won
- game_over  out  1  last game ended
- score  out  SCORE_WIDTH  accumulated score
- lives  out  2  remaining lives
- level  out  3  current level, 0-based

Function
REQ-007 Launch edge: launch_key registered once; launch_rise = launch_key & ~launch_key_q; only launch_rise is acted on.
REQ-008 FSM states SHALL be IDLE, ARM, AIM, FLY, RESOLVE, END_START, END_WAIT; each state's outputs are a function of state only (Moore), except as stated below.
REQ-009 IDLE: all strobes/enables 0; on launch_rise SHALL clear score, hit_cnt, level, load lives=LIVES_INIT, clear game_won/game_over, and go to ARM.
REQ-010 ARM: exactly one cycle; all four write_xy/write_dxy outputs = 1, both enables = 0; next AIM.
REQ-011 AIM: target_enable_update = 1, torpedo_enable_update = 0, torpedo_write_dxy = 1 every cycle (steering tracks keys), torpedo_write_xy = 0.
REQ-012 AIM exits: launch_rise -> FLY; else target_within_screen = 0 -> ARM (no penalty).
REQ-013 FLY: both enables = 1, all write strobes 0.
REQ-014 FLY exits, priority collision > exit: collision -> RESOLVE(hit); else torpedo_within_screen = 0 or target_within_screen = 0 -> RESOLVE(miss); hit/miss flag registered on entry.
REQ-015 RESOLVE, one cycle, hit: score += level+1, saturating at 2^SCORE_WIDTH-1; hit_cnt += 1. If hit_cnt reaches HITS_PER_LEVEL: hit_cnt = 0; if level = LEVEL_MAX, set game_won = 1 and go to END_START, else level += 1 and go to ARM. Otherwise ARM.
REQ-016 RESOLVE, miss: lives -= 1; if the result is 0, game_won = 0 and go to END_START, else ARM.
REQ-017 END_START: end_of_game_timer_start = 1 for exactly one cycle; game_over set to 1; next END_WAIT.
REQ-018 END_WAIT: both enables 0; exit to IDLE on the falling edge of end_of_game_timer_running (registered copy 1, current 0); launch_rise ignored.
REQ-019 score, lives, level, game_won, game_over SHALL hold their values through END_* and IDLE until the next game start.
REQ-020 launch_rise in ARM, FLY, RESOLVE, END_* SHALL be ignored; a collision outside FLY SHALL be ignored.
REQ-021 lives never underflows: decrement occurs only when lives >= 1.

Reset
REQ-022 On rst, from any state including mid-flight: state = IDLE; all strobes/enables/timer_start = 0; score = 0, lives = LIVES_INIT, level = 0, hit_cnt = 0, game_won = 0, game_over = 0, launch_key_q = 0.

Verification
REQ-023 Start: launch_key 0->1 in IDLE -> ARM for 1 cycle with all 4 writes = 1, then AIM with target_enable = 1; score = 0, lives = 3.
REQ-024 Hit at level 0: second launch_rise, then collision in FLY -> score = 1, hit_cnt = 1, ARM pulse follows; collision and torpedo exit in the same cycle -> counted as a hit.
REQ-025 Three misses (torpedo_within_screen = 0 in FLY) -> lives 3->2->1->0; timer_start is a single pulse; game_over = 1, game_won = 0; IDLE is reached only after running falls 1->0.
REQ-026 Win: LEVEL_MAX = 1, HITS_PER_LEVEL = 2, four hits -> level 0->1, score = 1+1+2+2 = 6, game_won = 1, END_START.
REQ-027 Saturation: SCORE_WIDTH = 3 with repeated hits -> score stops at 7.
REQ-028 Reset asserted during FLY -> next cycle state IDLE, all outputs at reset values, held launch_key produces no start until released and re-pressed.
